fetch_issue: RTL and testbench

FETCH_ISSUE -- requirements
Module: fetch_issue

---
 rtl/fetch_issue.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_issue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_issue.sv
// ---------------------------------------------------------------------------
// fetch_issue
//
// Purpose:
//   Single-outstanding instruction fetch unit.
//   - It requests one word from instruction memory.
//   - It waits for the returned data.
//   - It holds the instruction in front of the decoder until it is accepted.
//   - It then advances the pc.
//   A redirect (a resolved branch or jump) restarts fetch at a new address
//   and drops whatever is in flight or held.
//
// Optional feature (macro FETCH_RAS_EN):
//   Adds a 4-entry circular return-address stack.
//   - An accepted jump-in (opcode 6) pushes pc_out+1.
//   - An accepted jump-out (opcode 7) pops that entry, when one exists, as
//     the next fetch address and pulses ras_hit.
//   Without the macro there is no stack and ras_hit is tied low.
//
// Parameters:
//   PC_W      address / pc width
//   RESET_PC  first fetch address after reset
//
// Ports:
//   CLK             clock, rising edge
//   reset           synchronous, active-high reset
//   imem_req        instruction memory read request (one cycle per fetch)
//   imem_addr       word address of the request (0 when not requesting)
//   imem_valid      imem_data valid this cycle
//   imem_data       returned instruction word
//   issue_valid     instruction presented to the decoder
//   issue_ready     decoder accepts the instruction
//   opcode          instr[15:13] of the held instruction
//   func            instr[12:9] of the held instruction
//   instr           held instruction word
//   pc_out          address of the held instruction
//   redirect_valid  redirect request
//   redirect_pc     redirect target
//   ras_hit         one-cycle pulse when a return address was predicted
// ---------------------------------------------------------------------------
module fetch_issue #(
    parameter int                PC_W     = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [2:0]      opcode,
    output logic [3:0]      func,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] pc_out,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            ras_hit
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc_out;
    logic            w_capture;
    logic            w_handshake;
    logic            w_push;
    logic            w_pop;

`ifdef FETCH_RAS_EN
    logic [PC_W-1:0] r_ras [4];
    logic [1:0]      r_sp;       // next slot to write
    logic [2:0]      r_cnt;      // live entries, saturates at 4
    logic            r_ras_hit;
    logic [1:0]      w_top_idx;
    logic            w_ras_nonempty;

    assign w_top_idx      = r_sp - 2'd1;
    assign w_ras_nonempty = (r_cnt != 3'd0);
`endif

    // Outputs are gated by reset so they read as idle values during the
    // reset cycle itself, not only after the following edge.
    // A redirect withdraws issue_valid in the same cycle, so a held
    // instruction can never complete a handshake while it is discarded.
    assign imem_req    = (r_state == REQ) && !reset;
    assign imem_addr   = imem_req ? r_pc : '0;
    assign issue_valid = (r_state == HOLD) && !redirect_valid && !reset;
    assign w_handshake = issue_valid && issue_ready;

    assign instr  = r_instr;
    assign opcode = r_instr[15:13];
    assign func   = r_instr[12:9];
    assign pc_out = r_pc_out;

`ifdef FETCH_RAS_EN
    assign ras_hit = r_ras_hit;
`else
    assign ras_hit = 1'b0;
`endif

    // Next-state and next-pc decode.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_capture    = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    w_next_state = REQ;
                    w_next_pc    = redirect_pc;
                end else begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_next_state = REQ;
                    w_next_pc    = redirect_pc;
                end else if (imem_valid) begin
                    w_next_state = HOLD;
                    w_capture    = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_next_state = REQ;
                    w_next_pc    = redirect_pc;
                end else if (w_handshake) begin
                    w_next_state = REQ;
                    w_next_pc    = r_pc + PC_W'(1);
`ifdef FETCH_RAS_EN
                    if (opcode == 3'd6) begin
                        w_push = 1'b1;
                    end else if (opcode == 3'd7 && w_ras_nonempty) begin
                        w_pop     = 1'b1;
                        w_next_pc = r_ras[w_top_idx];
                    end
`endif
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Control state, pc and issued-instruction registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_pc_out <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_capture) begin
                r_instr  <= imem_data;
                r_pc_out <= r_pc;
            end
        end
    end

`ifdef FETCH_RAS_EN
    // Stack pointer/occupancy.
    // A push onto a full stack wraps over the oldest entry.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sp      <= 2'd0;
            r_cnt     <= 3'd0;
            r_ras_hit <= 1'b0;
        end else begin
            r_ras_hit <= w_pop;
            if (w_push) begin
                r_sp  <= r_sp + 2'd1;
                r_cnt <= (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
            end else if (w_pop) begin
                r_sp  <= w_top_idx;
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone defines validity.
    always_ff @(posedge CLK) begin
        if (!reset && w_push) begin
            r_ras[r_sp] <= r_pc_out + PC_W'(1);
        end
    end
`else
    // Without the stack, push/pop decode is never consumed.
    logic w_unused_ras;
    assign w_unused_ras = w_push | w_pop;
`endif

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic [15:0] instr;
    logic [15:0] pc_out;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ras_hit;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    fetch_issue #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_data      (imem_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .opcode         (opcode),
        .func           (func),
        .instr          (instr),
        .pc_out         (pc_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ras_hit        (ras_hit)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // REQ cycle then WAIT cycle with same-cycle memory response.
    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        #1;
        check("req_asserted", {31'd0, imem_req}, 32'd1);
        check("req_addr", {16'd0, imem_addr}, {16'd0, addr});
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        cyc();
        imem_valid = 1'b1;
        imem_data  = data;
        #1;
        check("wait_no_req", {31'd0, imem_req}, 32'd0);
        check("wait_no_issue", {31'd0, issue_valid}, 32'd0);
        cyc();
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
    endtask

    // HOLD cycle with issue_ready high: handshake compared against scoreboard.
    task automatic issue_now();
        exp_t e;
        issue_ready = 1'b1;
        #1;
        check("issue_valid", {31'd0, issue_valid}, 32'd1);
        check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc_out", {16'd0, pc_out}, {16'd0, e.addr});
            check("instr", {16'd0, instr}, {16'd0, e.data});
            check("opcode", {29'd0, opcode}, {29'd0, e.data[15:13]});
            check("func", {28'd0, func}, {28'd0, e.data[12:9]});
        end
        cyc();
        issue_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, {16'd0, imem_addr}, 32'd0);
        check({tag, "_iv"}, {31'd0, issue_valid}, 32'd0);
        check({tag, "_opcode"}, {29'd0, opcode}, 32'd0);
        check({tag, "_func"}, {28'd0, func}, 32'd0);
        check({tag, "_instr"}, {16'd0, instr}, 32'd0);
        check({tag, "_pc_out"}, {16'd0, pc_out}, 32'd0);
        check({tag, "_ras_hit"}, {31'd0, ras_hit}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_after_jout;
        logic        exp_hit;
        exp_t        dropped;

        reset          = 1'b1;
        imem_valid     = 1'b0;
        imem_data      = 16'h0000;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset held, with a redirect and handshake attempt that must be overridden.
        repeat (2) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0077;
        issue_ready    = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        issue_ready    = 1'b0;
        #1;
        check_idle_outputs("reset");

        // Release: one IDLE cycle, then REQ at RESET_PC.
        cyc();
        reset = 1'b0;
        #1;
        check("idle_no_req", {31'd0, imem_req}, 32'd0);
        cyc();

        // Back-to-back fetches at 0,1,2 with 3-cycle spacing.
        fetch_one(16'h0000, 16'h0001);
        issue_now();
        fetch_one(16'h0001, 16'h2002);
        issue_now();
        fetch_one(16'h0002, 16'h4003);
        issue_now();

        // Decoder stalls for 5 cycles: instruction held stable, no new request.
        fetch_one(16'h0003, 16'h2A00);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_iv", {31'd0, issue_valid}, 32'd1);
            check("stall_opcode", {29'd0, opcode}, 32'd1);
            check("stall_func", {28'd0, func}, 32'd5);
            check("stall_instr", {16'd0, instr}, 32'h2A00);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            cyc();
        end
        issue_now();

        // Redirect during HOLD together with issue_ready: held instruction dropped.
        fetch_one(16'h0004, 16'h4444);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        issue_ready    = 1'b1;
        #1;
        check("redir_iv_low", {31'd0, issue_valid}, 32'd0);
        dropped = sb.pop_front();
        cyc();
        redirect_valid = 1'b0;
        issue_ready    = 1'b0;
        fetch_one(16'h0040, 16'h0040);
        issue_now();

        // Redirect in REQ to the top of the address space, then wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        check("redir_req_addr", {16'd0, imem_addr}, 32'h0041);
        cyc();
        redirect_valid = 1'b0;
        fetch_one(16'hFFFF, 16'h1111);
        issue_now();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        #1;
        check("wrap_addr", {16'd0, imem_addr}, 32'h0000);
        check("wrap_req", {31'd0, imem_req}, 32'd1);
        cyc();
        redirect_valid = 1'b0;

        // Jump-in at 0x0010, then jump-out.
        fetch_one(16'h0010, 16'hC000);
        issue_now();
        fetch_one(16'h0011, 16'hE000);
        issue_now();
`ifdef FETCH_RAS_EN
        exp_after_jout = 16'h0011;
        exp_hit        = 1'b1;
`else
        exp_after_jout = 16'h0012;
        exp_hit        = 1'b0;
`endif
        #1;
        check("jout_addr", {16'd0, imem_addr}, {16'd0, exp_after_jout});
        check("jout_ras_hit", {31'd0, ras_hit}, {31'd0, exp_hit});
        cyc();

        // Now in WAIT: reset arrives, then late memory data the following cycle.
        reset = 1'b1;
        #1;
        check("rst_wait_req", {31'd0, imem_req}, 32'd0);
        check("ras_hit_pulse", {31'd0, ras_hit}, 32'd0);
        cyc();
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 16'hBEEF;
        #1;
        check_idle_outputs("rst_mid");
        cyc();
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        #1;
        check("late_instr", {16'd0, instr}, 32'h0000);
        check("late_iv", {31'd0, issue_valid}, 32'd0);
        fetch_one(16'h0000, 16'h0123);
        issue_now();

        // Jump-out with an empty stack falls through to pc+1.
        fetch_one(16'h0001, 16'hE000);
        issue_now();
        #1;
        check("jout_empty_addr", {16'd0, imem_addr}, 32'h0002);
        check("jout_empty_hit", {31'd0, ras_hit}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        check("dropped_addr", {16'd0, dropped.addr}, 32'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
